// File: rtl/sqrt_frac.sv
// Fixed-point square root, dout = floor(sqrt(din * 4^FRAC_W)), BPC radix-2 digits per clock.
// Define SQRT_REM_EN to add the dout_rem port (din*4^FRAC_W - dout^2).
module sqrt_frac #(
    parameter int DIN_W  = 32,
    parameter int FRAC_W = 0,
    parameter int BPC    = 1,
    localparam int DOUT_W = (DIN_W + 1) / 2 + FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready
`ifdef SQRT_REM_EN
    ,
    output logic [DOUT_W:0]   dout_rem
`endif
);

    localparam int N_ITER = (DOUT_W + BPC - 1) / BPC;
    // Q_W pads the root to a whole number of steps; extra top bits always resolve to 0.
    localparam int Q_W    = N_ITER * BPC;
    localparam int RAD_W  = 2 * Q_W;
    localparam int RM_W   = Q_W + 1;
    localparam int SH_W   = Q_W + 3;
    localparam int CNT_W  = $clog2(N_ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             r_state, w_next;
    logic               r_din_ready, r_dout_valid;
    logic [CNT_W-1:0]   r_cnt;
    logic [RAD_W-1:0]   r_rad;
    logic [Q_W-1:0]     r_q;
    logic [RM_W-1:0]    r_rem;
    logic [DOUT_W-1:0]  r_dout;

    logic [BPC:0][Q_W-1:0]    w_q;
    logic [BPC:0][RM_W-1:0]   w_r;
    logic [BPC-1:0][SH_W-1:0] w_sh, w_trial;

    // Restoring recurrence: bring down two radicand bits, try subtracting 4q+1.
    always_comb begin
        w_q[0]  = r_q;
        w_r[0]  = r_rem;
        w_sh    = '0;
        w_trial = '0;
        for (int k = 0; k < BPC; k++) begin
            w_sh[k]    = {w_r[k], r_rad[RAD_W-1-2*k -: 2]};
            w_trial[k] = SH_W'({w_q[k], 2'b01});
            if (w_sh[k] >= w_trial[k]) begin
                w_r[k+1] = RM_W'(w_sh[k] - w_trial[k]);
                w_q[k+1] = (w_q[k] << 1) | Q_W'(1);
            end else begin
                w_r[k+1] = RM_W'(w_sh[k]);
                w_q[k+1] = w_q[k] << 1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (din_valid && r_din_ready) w_next = S_CALC;
            S_CALC:  if (r_cnt == CNT_W'(1))      w_next = S_DONE;
            S_DONE:  if (dout_ready)              w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_din_ready  <= 1'b0;
            r_dout_valid <= 1'b0;
            r_cnt        <= '0;
            r_rad        <= '0;
            r_q          <= '0;
            r_rem        <= '0;
            r_dout       <= '0;
        end else begin
            r_din_ready  <= (w_next == S_IDLE);
            r_dout_valid <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: if (w_next == S_CALC) begin
                    r_rad <= RAD_W'(din) << (2 * FRAC_W);
                    r_q   <= '0;
                    r_rem <= '0;
                    r_cnt <= CNT_W'(N_ITER);
                end
                S_CALC: begin
                    r_rad <= r_rad << (2 * BPC);
                    r_q   <= w_q[BPC];
                    r_rem <= w_r[BPC];
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) r_dout <= w_q[BPC][DOUT_W-1:0];
                end
                default: ;
            endcase
        end
    end

`ifdef SQRT_REM_EN
    logic [DOUT_W:0] r_dout_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  r_dout_rem <= '0;
        else if (r_state == S_CALC && r_cnt == CNT_W'(1)) r_dout_rem <= w_r[BPC][DOUT_W:0];
    end

    assign dout_rem = r_dout_rem;
`endif

    assign din_ready  = r_din_ready;
    assign dout_valid = r_dout_valid;
    assign dout       = r_dout;

endmodule
